adder_result_checker: RTL and testbench

Synthesizable response checker for the 32-bit adder. It sits at the output end of the adder test harness, opposite the operand stimulus source. It records every operand set `{a, b, cin}` issued to the adder and computes the expected `{cout, sum}` at issue time. It queues the expected results in order, compares each one against the adder's returned result, and reports pass/fail counts, sticky status and first-failure details.

---
 rtl/adder_result_checker.sv | 174 +++++++++++++++++
 tb/tb_adder_result_checker.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_checker.sv
// Response checker for the 32-bit adder harness: queues expected sums, compares returns.
// Optional first-failure capture is built when ADDER_CHK_CAPTURE_EN is defined.
module adder_result_checker #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic                     in_cin,
  input  logic                     res_valid,
  input  logic [WIDTH-1:0]         res_sum,
  input  logic                     res_cout,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  output logic [CNT_W-1:0]         ff_idx,
  output logic [WIDTH:0]           ff_exp,
  output logic [WIDTH:0]           ff_got
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PASS = 2'b01,
    S_FAIL = 2'b10
  } state_e;

  logic [WIDTH:0]    mem_q [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [LW-1:0]     lvl_q, lvl_d;
  state_e            state_q;
  logic [CNT_W-1:0]  pass_q, fail_q;
  logic              ovf_q, ufl_q;

  logic              push, pop, empty, full;
  logic              do_push, do_pop, uflow, ovf_ev;
  logic              match, pass_ev, fail_ev;
  logic [WIDTH:0]    add_w, exp_w, got_w;

  assign add_w = {1'b0, in_a} + {1'b0, in_b}
               + {{WIDTH{1'b0}}, in_cin};
  assign exp_w = mem_q[rd_q];
  assign got_w = {res_cout, res_sum};

  // clr masks both valids so nothing moves in a clearing cycle
  assign push    = in_valid & ~clr;
  assign pop     = res_valid & ~clr;
  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == FULL_LVL);
  assign do_pop  = pop & ~empty;
  assign uflow   = pop & empty;
  assign do_push = push & (~full | do_pop);
  assign ovf_ev  = push & full & ~do_pop;
  assign match   = (exp_w == got_w);
  assign pass_ev = do_pop & match;
  assign fail_ev = (do_pop & ~match) | uflow;

  // Occupancy follows the net effect of push and pop
  always_comb begin
    lvl_d = lvl_q;
    unique case ({do_push, do_pop})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (clr) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_d;
    end
  end

  // Entry storage; pointers alone define which entries are live
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= add_w;
  end

  // Verdict FSM, saturating counters and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      fail_q  <= '0;
      ovf_q   <= 1'b0;
      ufl_q   <= 1'b0;
    end else if (clr) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      fail_q  <= '0;
      ovf_q   <= 1'b0;
      ufl_q   <= 1'b0;
    end else begin
      if (ovf_ev) ovf_q <= 1'b1;
      if (uflow)  ufl_q <= 1'b1;
      if (pass_ev && pass_q != '1) pass_q <= pass_q + 1'b1;
      if (fail_ev && fail_q != '1) fail_q <= fail_q + 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (fail_ev)      state_q <= S_FAIL;
          else if (pass_ev) state_q <= S_PASS;
        end
        S_PASS: if (fail_ev) state_q <= S_FAIL;
        S_FAIL: state_q <= S_FAIL;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign pass_cnt  = pass_q;
  assign fail_cnt  = fail_q;
  assign level     = lvl_q;
  assign overflow  = ovf_q;
  assign underflow = ufl_q;

`ifdef ADDER_CHK_CAPTURE_EN
  logic [CNT_W-1:0] txn_q, idx_q;
  logic [WIDTH:0]   fexp_q, fgot_q;

  // Transaction index and first-failure snapshot (taken while not yet FAIL)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_q  <= '0;
      idx_q  <= '0;
      fexp_q <= '0;
      fgot_q <= '0;
    end else if (clr) begin
      txn_q  <= '0;
      idx_q  <= '0;
      fexp_q <= '0;
      fgot_q <= '0;
    end else begin
      if (pop) txn_q <= txn_q + 1'b1;
      if (fail_ev && state_q != S_FAIL) begin
        idx_q  <= txn_q;
        fexp_q <= uflow ? '0 : exp_w;
        fgot_q <= got_w;
      end
    end
  end

  assign ff_idx = idx_q;
  assign ff_exp = fexp_q;
  assign ff_got = fgot_q;
`else
  assign ff_idx = '0;
  assign ff_exp = '0;
  assign ff_got = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Scoreboard bench for adder_result_checker (DEPTH=4, CNT_W=16).
// Expected sums queue up at issue and are popped when results are returned.
module tb_adder_result_checker;

  localparam int W = 32;
  localparam int D = 4;
  localparam int C = 16;
`ifdef ADDER_CHK_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_cin = 1'b0;
  logic          res_valid = 1'b0;
  logic [W-1:0]  res_sum = '0;
  logic          res_cout = 1'b0;
  logic [1:0]    state;
  logic [C-1:0]  pass_cnt, fail_cnt, ff_idx;
  logic [2:0]    level;
  logic          overflow, underflow;
  logic [W:0]    ff_exp, ff_got;

  int errors = 0;
  int checks = 0;

  logic [W:0]    sb[$];
  logic [C-1:0]  m_pass, m_fail, m_txn, m_idx;
  logic [1:0]    m_state;
  logic          m_ovf, m_ufl;
  logic [W:0]    m_exp, m_got;

  adder_result_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
    .in_cin(in_cin), .res_valid(res_valid),
    .res_sum(res_sum), .res_cout(res_cout),
    .state(state), .pass_cnt(pass_cnt),
    .fail_cnt(fail_cnt), .level(level),
    .overflow(overflow), .underflow(underflow),
    .ff_idx(ff_idx), .ff_exp(ff_exp), .ff_got(ff_got)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "timeout");
  end

  function automatic void m_clear();
    sb.delete();
    m_pass = '0; m_fail = '0; m_txn = '0; m_idx = '0;
    m_state = 2'b00; m_ovf = 1'b0; m_ufl = 1'b0;
    m_exp = '0; m_got = '0;
  endfunction

  function automatic void m_failed(logic [W:0] e,
                                   logic [W:0] g);
    if (m_fail != 16'hFFFF) m_fail = m_fail + 1;
    if (m_state != 2'b10) begin
      m_idx = m_txn; m_exp = e; m_got = g;
      m_state = 2'b10;
    end
  endfunction

  // one clock of stimulus; the model is advanced alongside
  task automatic drive(input bit iv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit ci,
                       input bit rv, input logic [W-1:0] s,
                       input bit co, input bit cl);
    logic [W:0] e, g;
    in_valid = iv; in_a = a; in_b = b; in_cin = ci;
    res_valid = rv; res_sum = s; res_cout = co; clr = cl;
    g = {co, s};
    if (cl) m_clear();
    else begin
      if (rv) begin
        if (sb.size() == 0) begin
          m_ufl = 1'b1;
          m_failed('0, g);
        end else begin
          e = sb.pop_front();
          if (e == g) begin
            if (m_pass != 16'hFFFF) m_pass = m_pass + 1;
            if (m_state == 2'b00) m_state = 2'b01;
          end else m_failed(e, g);
        end
        m_txn = m_txn + 1;
      end
      if (iv) begin
        if (sb.size() < D)
          sb.push_back(W'(a) + W'(b) + 33'(ci) + 33'd0
                       + {1'b0, 32'd0});
        else m_ovf = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; res_valid = 1'b0; clr = 1'b0;
  endtask

  task automatic pop_good();
    logic [W:0] e;
    e = sb[0];
    drive(0, '0, '0, 0, 1, e[W-1:0], e[W], 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (state !== 2'b00) begin errors++;
      $display("FAIL rst_state: got %b want 00", state); end
    checks++; if (pass_cnt !== '0 || fail_cnt !== '0) begin
      errors++; $display("FAIL rst_cnt: got %0d/%0d want 0/0",
                         pass_cnt, fail_cnt); end
    checks++; if (level !== '0 || overflow !== 1'b0
                  || underflow !== 1'b0) begin errors++;
      $display("FAIL rst_flags: lvl %0d ovf %b ufl %b want 0",
               level, overflow, underflow); end
    checks++; if (ff_idx !== '0 || ff_exp !== '0
                  || ff_got !== '0) begin errors++;
      $display("FAIL rst_ff: %0d %h %h want 0", ff_idx,
               ff_exp, ff_got); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    drive(1, 32'd16, 32'd8, 1, 0, '0, 0, 0);
    checks++; if (level !== 3'd1) begin errors++;
      $display("FAIL pass_push_lvl: got %0d want 1", level); end
    drive(0, '0, '0, 0, 1, 32'd25, 0, 0);
    checks++; if (pass_cnt !== 16'd1) begin errors++;
      $display("FAIL pass_cnt: got %0d want 1", pass_cnt); end
    checks++; if (state !== 2'b01 || level !== 3'd0) begin
      errors++; $display("FAIL pass_state: st %b lvl %0d want 01/0",
                         state, level); end
  endtask

  task automatic test_mismatch();
    drive(0, '0, '0, 0, 0, '0, 0, 1);
    drive(1, 32'd16, 32'd8, 1, 0, '0, 0, 0);
    drive(0, '0, '0, 0, 1, 32'd24, 0, 0);
    checks++; if (fail_cnt !== 16'd1 || state !== 2'b10) begin
      errors++; $display("FAIL mis_fail: cnt %0d st %b want 1/10",
                         fail_cnt, state); end
    checks++; if (ff_idx !== '0 || ff_exp !== (CAP ? 33'd25 : 33'd0)
                  || ff_got !== (CAP ? 33'd24 : 33'd0)) begin
      errors++; $display("FAIL mis_ff: %0d %0d %0d want %0d 25/24",
                         ff_idx, ff_exp, ff_got, 0); end
    drive(1, 32'd3, 32'd4, 0, 0, '0, 0, 0);
    drive(0, '0, '0, 0, 1, 32'd7, 0, 0);
    checks++; if (state !== 2'b10 || pass_cnt !== 16'd1) begin
      errors++; $display("FAIL mis_sticky: st %b pass %0d want 10/1",
                         state, pass_cnt); end
    checks++; if (ff_exp !== (CAP ? 33'd25 : 33'd0)) begin
      errors++; $display("FAIL mis_ff_hold: got %0d", ff_exp); end
  endtask

  task automatic test_carry();
    drive(0, '0, '0, 0, 0, '0, 0, 1);
    drive(1, 32'hFFFF_FFFF, 32'd1, 0, 0, '0, 0, 0);
    drive(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,
          1, 32'h0000_0000, 1, 0);
    drive(0, '0, '0, 0, 1, 32'hFFFF_FFFF, 1, 0);
    checks++; if (pass_cnt !== 16'd2 || fail_cnt !== '0) begin
      errors++; $display("FAIL carry: pass %0d fail %0d want 2/0",
                         pass_cnt, fail_cnt); end
    checks++; if (level !== 3'd0 || state !== 2'b01) begin
      errors++; $display("FAIL carry_st: lvl %0d st %b want 0/01",
                         level, state); end
  endtask

  task automatic test_underflow();
    drive(0, '0, '0, 0, 0, '0, 0, 1);
    drive(0, '0, '0, 0, 1, 32'd7, 0, 0);
    checks++; if (underflow !== 1'b1 || fail_cnt !== 16'd1
                  || state !== 2'b10) begin errors++;
      $display("FAIL ufl: u %b f %0d st %b want 1/1/10",
               underflow, fail_cnt, state); end
    checks++; if (ff_exp !== '0 || ff_got !== (CAP ? 33'd7 : 33'd0))
    begin errors++;
      $display("FAIL ufl_ff: exp %0d got %0d", ff_exp, ff_got); end
    drive(0, '0, '0, 0, 0, '0, 0, 1);
    drive(1, 32'd5, 32'd6, 0, 1, 32'd11, 0, 0);
    checks++; if (underflow !== 1'b1 || fail_cnt !== 16'd1
                  || level !== 3'd1) begin errors++;
      $display("FAIL ufl_push: u %b f %0d lvl %0d want 1/1/1",
               underflow, fail_cnt, level); end
    pop_good();
    checks++; if (pass_cnt !== 16'd1 || level !== 3'd0
                  || state !== 2'b10) begin errors++;
      $display("FAIL ufl_drain: p %0d lvl %0d st %b want 1/0/10",
               pass_cnt, level, state); end
  endtask

  task automatic test_overflow();
    logic [W:0] e;
    drive(0, '0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < D; i++)
      drive(1, 32'(i * 100 + 1), 32'(i), i[0], 0, '0, 0, 0);
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_fill: lvl %0d ovf %b want 4/0",
                         level, overflow); end
    e = sb[0];
    drive(1, 32'd900, 32'd9, 1, 1, e[W-1:0], e[W], 0);
    checks++; if (level !== 3'd4 || overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_pp: lvl %0d ovf %b want 4/0",
                         level, overflow); end
    drive(1, 32'd777, 32'd7, 0, 0, '0, 0, 0);
    checks++; if (level !== 3'd4 || overflow !== 1'b1
                  || state !== 2'b01) begin errors++;
      $display("FAIL ovf_set: lvl %0d ovf %b st %b want 4/1/01",
               level, overflow, state); end
    while (sb.size() > 0) pop_good();
    checks++; if (pass_cnt !== 16'd5 || fail_cnt !== '0) begin
      errors++; $display("FAIL ovf_drain: p %0d f %0d want 5/0",
                         pass_cnt, fail_cnt); end
  endtask

  task automatic test_async_reset();
    drive(0, '0, '0, 0, 0, '0, 0, 1);
    drive(0, '0, '0, 0, 1, 32'd1, 0, 0);
    for (int i = 0; i < 3; i++)
      drive(1, 32'(i + 40), 32'd2, 0, 0, '0, 0, 0);
    checks++; if (level !== 3'd3 || fail_cnt !== 16'd1) begin
      errors++; $display("FAIL arst_pre: lvl %0d f %0d want 3/1",
                         level, fail_cnt); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    checks++; if (level !== '0 || fail_cnt !== '0 || state !== '0
                  || underflow !== 1'b0 || ff_got !== '0) begin
      errors++; $display("FAIL arst: lvl %0d f %0d st %b u %b g %0d",
                         level, fail_cnt, state, underflow, ff_got);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, '0, '0, 0, 1, 32'd42, 0, 0);
    checks++; if (underflow !== 1'b1 || level !== '0) begin
      errors++; $display("FAIL arst_empty: u %b lvl %0d want 1/0",
                         underflow, level); end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++)
      drive(1, 32'(i + 10), 32'd5, 1, 0, '0, 0, 0);
    drive(1, 32'd1, 32'd1, 0, 1, 32'd0, 1, 1);
    checks++; if (level !== '0 || pass_cnt !== '0 || fail_cnt !== '0
                  || state !== '0) begin errors++;
      $display("FAIL clr: lvl %0d p %0d f %0d st %b want 0",
               level, pass_cnt, fail_cnt, state); end
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0
                  || ff_idx !== '0 || ff_exp !== '0
                  || ff_got !== '0) begin errors++;
      $display("FAIL clr_flags: o %b u %b ff %0d %0d %0d",
               overflow, underflow, ff_idx, ff_exp, ff_got); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b;
    logic [W:0]   e;
    bit           ci;
    drive(0, '0, '0, 0, 0, '0, 0, 1);
    for (int i = 0; i < 65540; i++) begin
      a = $urandom(); b = $urandom(); ci = i[0];
      if (sb.size() > 0) begin
        e = sb[0];
        drive(1, a, b, ci, 1, e[W-1:0], e[W], 0);
      end else drive(1, a, b, ci, 0, '0, 0, 0);
    end
    pop_good();
    checks++; if (pass_cnt !== 16'hFFFF || pass_cnt !== m_pass) begin
      errors++; $display("FAIL sat: got %h want FFFF", pass_cnt); end
    checks++; if (fail_cnt !== '0 || state !== 2'b01
                  || level !== '0) begin errors++;
      $display("FAIL sat_st: f %0d st %b lvl %0d want 0/01/0",
               fail_cnt, state, level); end
    e = {1'b0, 32'h1234_5678};
    drive(1, 32'h1234_0000, 32'h5678, 0, 0, '0, 0, 0);
    drive(0, '0, '0, 0, 1, e[W-1:0] ^ 32'd1, 0, 0);
    checks++; if (fail_cnt !== m_fail || state !== m_state
                  || ff_idx !== (CAP ? m_idx : 16'd0)) begin errors++;
      $display("FAIL wrap_idx: f %0d st %b idx %0d want %0d %b %0d",
               fail_cnt, state, ff_idx, m_fail, m_state, m_idx); end
  endtask

  initial begin
    m_clear();
    test_reset();
    test_pass();
    test_mismatch();
    test_carry();
    test_underflow();
    test_overflow();
    test_async_reset();
    test_clr();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
